// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: CP0 register numbers, ExcCodes, field positions and defaults
package cp0_exc_ctrl_pkg;
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int SR_IM_LO = 10;
    localparam int CAUSE_BD = 31;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_DEF       = 32'h4D49_5053;
    typedef enum logic {RUN, HANDLER} cp0State_t;
    function automatic logic [31:0] wordAlign(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: pipeline-side bundle between the M stage and CP0
interface cp0_exc_ctrl_if;
    logic [4:0]  exc_code_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    modport master (
        output exc_code_m, pc_m, bd_m, hw_int, eret_m, cp0_we, cp0_addr, cp0_wdata,
        input  cp0_rdata, exc_req, eret_req, redirect_pc, epc
    );
    modport slave (
        input  exc_code_m, pc_m, bd_m, hw_int, eret_m, cp0_we, cp0_addr, cp0_wdata,
        output cp0_rdata, exc_req, eret_req, redirect_pc, epc
    );
endinterface

// File: rtl/cp0_int_sync.sv
// cp0_int_sync: registers Cause.IP from hw_int and qualifies the interrupt request
module cp0_int_sync (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hwInt,
    input  logic [5:0]  im,
    input  logic        ie,
    input  logic        exl,
    input  logic [31:0] pcM,
    output logic [5:0]  ip,
    output logic        intReq
);
    always_ff @(posedge clk)
        ip <= reset ? 6'd0 : hwInt;
    // a bubble has no PC to return to, so the interrupt waits for a real instruction
    assign intReq = |(ip & im) & ie & !exl & (pcM != 32'd0);
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt controller owning SR, Cause, EPC and PRId
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] PRID_VAL   = PRID_DEF
) (
    input logic clk,
    input logic reset,
    cp0_exc_ctrl_if.slave bus
);
    cp0State_t state;
    logic [5:0] im, ip;
    logic ie, bd, exl, intReq, excTake, excReq, eretReq, mtc0;
    logic [4:0] excCode;
    logic [31:0] epcReg, epcNext;
    assign exl = state == HANDLER;
    cp0_int_sync uIntSync (
        .clk(clk), .reset(reset), .hwInt(bus.hw_int), .im(im), .ie(ie),
        .exl(exl), .pcM(bus.pc_m), .ip(ip), .intReq(intReq)
    );
    assign excTake = (bus.exc_code_m != EXC_INT) & !exl;
    assign excReq  = intReq | excTake;
    assign eretReq = bus.eret_m & !excReq;
    assign mtc0    = bus.cp0_we & !excReq & !eretReq;
    assign epcNext = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
    assign bus.exc_req     = excReq;
    assign bus.eret_req    = eretReq;
    assign bus.redirect_pc = excReq ? HANDLER_PC : eretReq ? epcReg : 32'd0;
    assign bus.epc         = epcReg;
    always_comb
        bus.cp0_rdata = bus.cp0_addr == CP0_SR    ? {16'd0, im, 8'd0, exl, ie} :
                        bus.cp0_addr == CP0_CAUSE ? {bd, 15'd0, ip, 3'd0, excCode, 2'd0} :
                        bus.cp0_addr == CP0_EPC   ? epcReg :
                        bus.cp0_addr == CP0_PRID  ? PRID_VAL : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            im      <= 6'd0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            excCode <= 5'd0;
            epcReg  <= 32'd0;
        end else if (excReq) begin
            state   <= HANDLER;
            excCode <= intReq ? EXC_INT : bus.exc_code_m;
            bd      <= bus.bd_m;
            epcReg  <= wordAlign(epcNext);
        end else if (eretReq) begin
            state <= RUN;
        end else if (mtc0) begin
            if (bus.cp0_addr == CP0_SR) begin
                im    <= bus.cp0_wdata[SR_IM_LO +: 6];
                ie    <= bus.cp0_wdata[SR_IE];
                state <= bus.cp0_wdata[SR_EXL] ? HANDLER : RUN;
            end
            if (bus.cp0_addr == CP0_EPC)
                epcReg <= wordAlign(bus.cp0_wdata);
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized checks of cp0_exc_ctrl against a word-level model
module tb_cp0_exc_ctrl;
    import cp0_exc_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] mSr, mCause, mEpc;
    cp0_exc_ctrl_if bus ();
    cp0_exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic mInt();
        return ((mCause & mSr & 32'h0000_FC00) != 0) && mSr[0] && !mSr[1] && bus.pc_m != 0;
    endfunction
    function automatic logic mExc();
        return mInt() || (bus.exc_code_m != 0 && !mSr[1]);
    endfunction
    function automatic logic mEret();
        return bus.eret_m && !mExc();
    endfunction
    function automatic logic [31:0] mRead(input logic [4:0] a);
        return a == 12 ? mSr : a == 13 ? mCause : a == 14 ? mEpc : a == 15 ? 32'h4D49_5053 : 32'd0;
    endfunction

    task automatic setIn(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [5:0] hw, input logic eret, input logic we,
                         input logic [4:0] addr, input logic [31:0] wdata);
        bus.exc_code_m = code; bus.pc_m = pc; bus.bd_m = bd; bus.hw_int = hw;
        bus.eret_m = eret; bus.cp0_we = we; bus.cp0_addr = addr; bus.cp0_wdata = wdata;
    endtask

    task automatic adv();
        logic i, x, e;
        if (reset) begin
            mSr = 0; mCause = 0; mEpc = 0;
        end else begin
            i = mInt(); x = mExc(); e = mEret();
            if (x) begin
                mSr = mSr | 32'h2;
                mCause = (bus.bd_m ? 32'h8000_0000 : 32'd0) | ({27'd0, (i ? 5'd0 : bus.exc_code_m)} << 2);
                mEpc = (bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m) & 32'hFFFF_FFFC;
            end else if (e) begin
                mSr = mSr & ~32'h2;
            end else if (bus.cp0_we) begin
                if (bus.cp0_addr == 12) mSr = bus.cp0_wdata & 32'h0000_FC03;
                if (bus.cp0_addr == 14) mEpc = bus.cp0_wdata & 32'hFFFF_FFFC;
            end
            mCause = (mCause & ~32'h0000_FC00) | ({26'd0, bus.hw_int} << 10);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clk);
        total++;
        if (bus.exc_req !== 0 || bus.eret_req !== 0 || bus.redirect_pc !== 0 || bus.epc !== 0) begin
            bad++; $display("FAIL reset_outputs exc=%b eret=%b redir=%h epc=%h want 0", bus.exc_req, bus.eret_req, bus.redirect_pc, bus.epc);
        end
        bus.cp0_addr = CP0_SR; #1;
        total++;
        if (bus.cp0_rdata !== 0) begin bad++; $display("FAIL reset_sr got %h want 0", bus.cp0_rdata); end
        bus.cp0_addr = CP0_CAUSE; #1;
        total++;
        if (bus.cp0_rdata !== 0) begin bad++; $display("FAIL reset_cause got %h want 0", bus.cp0_rdata); end
        bus.cp0_addr = CP0_PRID; #1;
        total++;
        if (bus.cp0_rdata !== 32'h4D49_5053) begin bad++; $display("FAIL prid got %h want 4d495053", bus.cp0_rdata); end
        bus.cp0_addr = 5'd3; #1;
        total++;
        if (bus.cp0_rdata !== 0) begin bad++; $display("FAIL other_reg got %h want 0", bus.cp0_rdata); end
        adv();
    endtask

    task automatic test_interrupt();
        doReset();
        setIn(0, 0, 0, 0, 0, 1, CP0_SR, 32'h0000_FC01);
        @(negedge clk);
        total++;
        if (bus.cp0_rdata !== 0) begin bad++; $display("FAIL mfc0_old got %h want 0", bus.cp0_rdata); end
        adv();
        setIn(0, 32'h3010, 0, 6'b000100, 0, 0, CP0_SR, 0);
        @(negedge clk);
        total++;
        if (bus.exc_req !== 0) begin bad++; $display("FAIL int_latency exc=%b want 0", bus.exc_req); end
        adv();
        @(negedge clk);
        total++;
        if (bus.exc_req !== 1 || bus.redirect_pc !== 32'h4180) begin
            bad++; $display("FAIL int_take exc=%b redir=%h want 1 00004180", bus.exc_req, bus.redirect_pc);
        end
        adv();
        setIn(0, 0, 0, 0, 0, 0, CP0_EPC, 0);
        @(negedge clk);
        total++;
        if (bus.cp0_rdata !== 32'h3010) begin bad++; $display("FAIL int_epc got %h want 00003010", bus.cp0_rdata); end
        bus.cp0_addr = CP0_CAUSE; #1;
        total++;
        if (bus.cp0_rdata[6:2] !== 0) begin bad++; $display("FAIL int_code got %0d want 0", bus.cp0_rdata[6:2]); end
        bus.cp0_addr = CP0_SR; #1;
        total++;
        if (bus.cp0_rdata !== 32'h0000_FC03) begin bad++; $display("FAIL int_sr got %h want 0000fc03", bus.cp0_rdata); end
        adv();
    endtask

    task automatic test_exc_bd();
        doReset();
        setIn(EXC_RI, 32'h3024, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.exc_req !== 1 || bus.redirect_pc !== 32'h4180) begin
            bad++; $display("FAIL ri_take exc=%b redir=%h want 1 00004180", bus.exc_req, bus.redirect_pc);
        end
        adv();
        setIn(0, 0, 0, 0, 0, 0, CP0_EPC, 0);
        @(negedge clk);
        total++;
        if (bus.cp0_rdata !== 32'h3020) begin bad++; $display("FAIL bd_epc got %h want 00003020", bus.cp0_rdata); end
        bus.cp0_addr = CP0_CAUSE; #1;
        total++;
        if (bus.cp0_rdata !== 32'h8000_0028) begin bad++; $display("FAIL bd_cause got %h want 80000028", bus.cp0_rdata); end
        adv();
    endtask

    task automatic test_nested();
        setIn(EXC_OV, 32'h3100, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.exc_req !== 0 || bus.eret_req !== 0) begin
            bad++; $display("FAIL nested_ignored exc=%b eret=%b want 0 0", bus.exc_req, bus.eret_req);
        end
        adv();
        setIn(0, 0, 0, 0, 0, 0, CP0_CAUSE, 0);
        @(negedge clk);
        total++;
        if (bus.cp0_rdata !== 32'h8000_0028 || bus.epc !== 32'h3020) begin
            bad++; $display("FAIL nested_regs cause=%h epc=%h want 80000028 00003020", bus.cp0_rdata, bus.epc);
        end
        adv();
    endtask

    task automatic test_eret();
        setIn(0, 32'h4190, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.eret_req !== 1 || bus.exc_req !== 0 || bus.redirect_pc !== 32'h3020) begin
            bad++; $display("FAIL eret eret=%b exc=%b redir=%h want 1 0 00003020", bus.eret_req, bus.exc_req, bus.redirect_pc);
        end
        adv();
        setIn(0, 0, 0, 0, 0, 0, CP0_SR, 0);
        @(negedge clk);
        total++;
        if (bus.cp0_rdata !== 0) begin bad++; $display("FAIL eret_exl got %h want 0", bus.cp0_rdata); end
        adv();
    endtask

    task automatic test_mtc0_dropped();
        doReset();
        setIn(EXC_ADEL, 32'h3000, 0, 0, 0, 1, CP0_EPC, 32'h5000);
        @(negedge clk);
        total++;
        if (bus.exc_req !== 1) begin bad++; $display("FAIL adel_take exc=%b want 1", bus.exc_req); end
        adv();
        setIn(0, 0, 0, 0, 0, 0, CP0_CAUSE, 0);
        @(negedge clk);
        total++;
        if (bus.epc !== 32'h3000 || bus.cp0_rdata !== 32'h10) begin
            bad++; $display("FAIL mtc0_dropped epc=%h cause=%h want 00003000 00000010", bus.epc, bus.cp0_rdata);
        end
        adv();
    endtask

    task automatic test_bubble_defer();
        doReset();
        setIn(0, 0, 0, 0, 0, 1, CP0_SR, 32'h0000_FC01);
        adv();
        setIn(0, 0, 0, 6'b000001, 0, 0, 0, 0);
        adv();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.exc_req !== 0) begin bad++; $display("FAIL bubble_defer cyc=%0d exc=%b want 0", i, bus.exc_req); end
            adv();
        end
        bus.pc_m = 32'h3040;
        @(negedge clk);
        total++;
        if (bus.exc_req !== 1) begin bad++; $display("FAIL defer_take exc=%b want 1", bus.exc_req); end
        adv();
        setIn(0, 0, 0, 0, 0, 0, CP0_CAUSE, 0);
        @(negedge clk);
        total++;
        if (bus.epc !== 32'h3040 || bus.cp0_rdata !== 32'h400) begin
            bad++; $display("FAIL defer_regs epc=%h cause=%h want 00003040 00000400", bus.epc, bus.cp0_rdata);
        end
        adv();
    endtask

    task automatic test_random();
        logic [4:0] code, addr;
        logic [31:0] pc;
        doReset();
        for (int n = 0; n < 600; n++) begin
            reset = $urandom_range(0, 59) == 0;
            code = $urandom_range(0, 4) == 0 ? 5'($urandom_range(1, 31)) : 5'd0;
            pc = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
            addr = $urandom_range(0, 4) == 0 ? 5'($urandom) : 5'($urandom_range(12, 15));
            setIn(code, pc, 1'($urandom), $urandom_range(0, 2) == 0 ? 6'($urandom) : 6'd0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, addr, $urandom);
            @(negedge clk);
            total++;
            if (bus.exc_req !== mExc() || bus.eret_req !== mEret() || bus.epc !== mEpc ||
                bus.redirect_pc !== (mExc() ? 32'h4180 : mEret() ? mEpc : 32'd0) ||
                bus.cp0_rdata !== mRead(addr)) begin
                bad++;
                $display("FAIL random n=%0d exc=%b/%b eret=%b/%b redir=%h/%h epc=%h/%h rd=%h/%h (got/want)",
                         n, bus.exc_req, mExc(), bus.eret_req, mEret(), bus.redirect_pc,
                         mExc() ? 32'h4180 : mEret() ? mEpc : 32'd0, bus.epc, mEpc, bus.cp0_rdata, mRead(addr));
            end
            adv();
        end
        reset = 1'b0;
    endtask

    initial begin
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_interrupt();
        test_exc_bd();
        test_nested();
        test_eret();
        test_mtc0_dropped();
        test_bubble_defer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
